// File: rtl/mc_ctrl_pkg.sv
// Shared types and constants for the multi-cycle RV32I control sequencer.
// Optional feature macro: MC_CTRL_ILLEGAL_TRAP_EN (adds the TRAP state).
package mc_ctrl_pkg;

  // Sequencer states; encodings 4'd11..4'd15 are unused and recover to IDLE
  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    FETCH    = 4'd1,
    DECODE   = 4'd2,
    EXEC_R   = 4'd3,
    R_WB     = 4'd4,
    MEM_ADDR = 4'd5,
    MEM_RD   = 4'd6,
    MEM_WB   = 4'd7,
    MEM_WR   = 4'd8,
    BRANCH   = 4'd9
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    ,
    TRAP     = 4'd10
`endif
  } state_t;

  // Instruction opcode field [6:2]
  localparam logic [4:0] OP_R      = 5'b01100;
  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_BRANCH = 5'b11000;

  // ALU operation select
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  // ALU B-operand select
  localparam logic [1:0] ALUB_RS2    = 2'b00;
  localparam logic [1:0] ALUB_FOUR   = 2'b01;
  localparam logic [1:0] ALUB_IMM    = 2'b10;
  localparam logic [1:0] ALUB_IMM_SH = 2'b11;

  // Bundle of datapath control strobes produced each cycle
  typedef struct packed {
    logic       ir_write;
    logic       pc_we;
    logic       pc_src;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_t;

  // True for the four opcodes this sequencer knows how to execute
  function automatic logic op_known(input logic [4:0] op);
    logic known;
    case (op)
      OP_R, OP_LOAD, OP_STORE, OP_BRANCH: known = 1'b1;
      default:                            known = 1'b0;
    endcase
    return known;
  endfunction

endpackage

// File: rtl/mc_ctrl_out_dec.sv
// Combinational decode of the sequencer state (plus mem_ready / zero) into
// datapath control strobes. Anything not driven by a state stays 0.
// Optional feature macro: MC_CTRL_ILLEGAL_TRAP_EN (drives illegal in TRAP).
module mc_ctrl_out_dec
  import mc_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic       mem_ready,
  input  logic       zero,
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  output logic       illegal,
`endif
  output ctrl_t      ctrl
);

  // Per-state control strobe decode
  always_comb begin
    ctrl = '0;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    illegal = 1'b0;
`endif
    case (state)
      IDLE: begin
        ctrl = '0;
      end
      FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.i_or_d    = 1'b0;
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = ALUB_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_src    = 1'b0;
        // IR and PC update only in the cycle memory delivers the word
        if (mem_ready) begin
          ctrl.ir_write = 1'b1;
          ctrl.pc_we    = 1'b1;
        end else begin
          ctrl.ir_write = 1'b0;
          ctrl.pc_we    = 1'b0;
        end
      end
      DECODE: begin
        // Branch target precomputed into ALUOut while decoding
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = ALUB_IMM_SH;
        ctrl.alu_op    = ALU_ADD;
      end
      EXEC_R: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALUB_RS2;
        ctrl.alu_op    = ALU_FUNCT;
      end
      R_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b0;
      end
      MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALUB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      MEM_WR: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      BRANCH: begin
        // Compare rs1-rs2; PC takes the precomputed target only when equal
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALUB_RS2;
        ctrl.alu_op    = ALU_SUB;
        ctrl.pc_src    = 1'b1;
        ctrl.pc_we     = zero;
      end
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      TRAP: begin
        ctrl    = '0;
        illegal = 1'b1;
      end
`endif
      default: begin
        ctrl = '0;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer for the RV32I R-type / load / store / BEQ subset.
// Holds the state register and the retired-instruction counter; the output
// strobes come from mc_ctrl_out_dec.
// Optional feature macro: MC_CTRL_ILLEGAL_TRAP_EN -- unknown opcodes enter a
// sticky TRAP state and raise illegal_o; otherwise they retire as NOPs.
module multicycle_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             ir_write,
  output logic             pc_we,
  output logic             pc_src,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [3:0]       state_o,
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  output logic             illegal_o,
`endif
  output logic [CNT_W-1:0] instr_retired
);

  state_t           state_r;
  ctrl_t            ctrl_s;
  logic             retire_s;
  logic [CNT_W-1:0] cnt_r;

  // State sequencing; unused encodings fall back to IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      case (state_r)
        IDLE:     state_r <= FETCH;
        FETCH:    state_r <= mem_ready ? DECODE : FETCH;
        DECODE: begin
          case (opcode)
            OP_R:              state_r <= EXEC_R;
            OP_LOAD, OP_STORE: state_r <= MEM_ADDR;
            OP_BRANCH:         state_r <= BRANCH;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            default:           state_r <= TRAP;
`else
            default:           state_r <= FETCH;
`endif
          endcase
        end
        EXEC_R:   state_r <= R_WB;
        R_WB:     state_r <= FETCH;
        // IR is stable here, so the opcode picks read vs write directly
        MEM_ADDR: state_r <= (opcode == OP_STORE) ? MEM_WR : MEM_RD;
        MEM_RD:   state_r <= mem_ready ? MEM_WB : MEM_RD;
        MEM_WB:   state_r <= FETCH;
        MEM_WR:   state_r <= mem_ready ? FETCH : MEM_WR;
        BRANCH:   state_r <= FETCH;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        TRAP:     state_r <= TRAP;
`endif
        default:  state_r <= IDLE;
      endcase
    end
  end

  // Identify the edge on which the current instruction retires
  always_comb begin
    retire_s = 1'b0;
    case (state_r)
      R_WB, MEM_WB, BRANCH: retire_s = 1'b1;
      MEM_WR:               retire_s = mem_ready;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      DECODE:               retire_s = 1'b0;
`else
      DECODE:               retire_s = ~op_known(opcode);
`endif
      default:              retire_s = 1'b0;
    endcase
  end

  // Retired-instruction counter, wraps silently
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (retire_s) begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  mc_ctrl_out_dec u_out_dec (
    .state     (state_r),
    .mem_ready (mem_ready),
    .zero      (zero),
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    .illegal   (illegal_o),
`endif
    .ctrl      (ctrl_s)
  );

  assign ir_write      = ctrl_s.ir_write;
  assign pc_we         = ctrl_s.pc_we;
  assign pc_src        = ctrl_s.pc_src;
  assign i_or_d        = ctrl_s.i_or_d;
  assign mem_read      = ctrl_s.mem_read;
  assign mem_write     = ctrl_s.mem_write;
  assign mem_to_reg    = ctrl_s.mem_to_reg;
  assign reg_write     = ctrl_s.reg_write;
  assign alu_src_a     = ctrl_s.alu_src_a;
  assign alu_src_b     = ctrl_s.alu_src_b;
  assign alu_op        = ctrl_s.alu_op;
  assign state_o       = state_r;
  assign instr_retired = cnt_r;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl (CNT_W=4 so counter wrap is reachable).
// Each cycle pushes the expected state/strobes/count to a scoreboard queue
// and pops it once the DUT outputs have settled after the falling edge.
// Honours MC_CTRL_ILLEGAL_TRAP_EN for the illegal-opcode case.
module tb_multicycle_ctrl;
  import mc_ctrl_pkg::*;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [4:0]    opcode = 5'b00000;
  logic          zero = 1'b0;
  logic          mem_ready = 1'b0;
  logic          ir_write, pc_we, pc_src, i_or_d, mem_read, mem_write;
  logic          mem_to_reg, reg_write, alu_src_a;
  logic [1:0]    alu_src_b, alu_op;
  logic [3:0]    state_o;
  logic [CW-1:0] instr_retired;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  logic          illegal_o;
`endif

  multicycle_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .ir_write(ir_write), .pc_we(pc_we), .pc_src(pc_src), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .state_o(state_o),
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    .illegal_o(illegal_o),
`endif
    .instr_retired(instr_retired)
  );

  always #5 clk = ~clk;

  // Packs strobes as {ir,pc_we,pc_src,i_or_d,mrd,mwr,m2r,rw,asa,asb,aop}
  function automatic logic [12:0] ctl(input logic ir, input logic pw, input logic ps,
                                      input logic iod, input logic mr, input logic mw,
                                      input logic m2r, input logic rw, input logic asa,
                                      input logic [1:0] asb, input logic [1:0] aop);
    return {ir, pw, ps, iod, mr, mw, m2r, rw, asa, asb, aop};
  endfunction

  localparam logic [12:0] C_ZERO   = 13'd0;
  localparam logic [12:0] C_F_WAIT = ctl(1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00);
  localparam logic [12:0] C_F_GO   = ctl(1'b1,1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00);
  localparam logic [12:0] C_DEC    = ctl(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00);
  localparam logic [12:0] C_EXR    = ctl(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b10);
  localparam logic [12:0] C_RWB    = ctl(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,2'b00);
  localparam logic [12:0] C_MADDR  = ctl(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00);
  localparam logic [12:0] C_MRD    = ctl(1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00);
  localparam logic [12:0] C_MWB    = ctl(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,2'b00);
  localparam logic [12:0] C_MWR    = ctl(1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,2'b00);
  localparam logic [12:0] C_BR_T   = ctl(1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01);
  localparam logic [12:0] C_BR_N   = ctl(1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01);

  localparam logic [4:0] O_R  = 5'b01100;
  localparam logic [4:0] O_LD = 5'b00000;
  localparam logic [4:0] O_ST = 5'b01000;
  localparam logic [4:0] O_BQ = 5'b11000;
  localparam logic [4:0] O_IL = 5'b11111;

  typedef struct packed {
    logic [3:0]    st;
    logic [12:0]   c;
    logic [CW-1:0] cnt;
    logic          ill;
  } exp_t;

  exp_t          sb_q[$];
  int            checks = 0;
  int            failures = 0;
  logic [CW-1:0] exp_cnt = '0;

  // Drive one cycle of inputs, record the expectation, then compare once settled
  task automatic cyc(input logic [4:0] op, input logic rdy, input logic z,
                     input state_t st, input logic [12:0] c, input logic ill);
    exp_t e;
    logic [12:0] obs;
    opcode = op; mem_ready = rdy; zero = z;
    e.st = st; e.c = c; e.cnt = exp_cnt; e.ill = ill;
    sb_q.push_back(e);
    #1;
    e = sb_q.pop_front();
    obs = {ir_write, pc_we, pc_src, i_or_d, mem_read, mem_write, mem_to_reg,
           reg_write, alu_src_a, alu_src_b, alu_op};
    checks++;
    assert (state_o === e.st) else begin
      failures++; $error("FAIL state obs=%0d exp=%0d t=%0t", state_o, e.st, $time);
    end
    checks++;
    assert (obs === e.c) else begin
      failures++; $error("FAIL ctrl obs=%b exp=%b t=%0t", obs, e.c, $time);
    end
    checks++;
    assert (instr_retired === e.cnt) else begin
      failures++; $error("FAIL retired obs=%0d exp=%0d t=%0t", instr_retired, e.cnt, $time);
    end
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    checks++;
    assert (illegal_o === e.ill) else begin
      failures++; $error("FAIL illegal obs=%b exp=%b t=%0t", illegal_o, e.ill, $time);
    end
`endif
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp_cnt = '0;
    cyc(O_LD, 1'b1, 1'b0, IDLE, C_ZERO, 1'b0);
    rst_n = 1'b1;
    cyc(O_LD, 1'b1, 1'b0, IDLE, C_ZERO, 1'b0);
  endtask

  task automatic beq(input logic z);
    cyc(O_BQ, 1'b1, z, FETCH, C_F_GO, 1'b0);
    cyc(O_BQ, 1'b0, z, DECODE, C_DEC, 1'b0);
    cyc(O_BQ, 1'b0, z, BRANCH, z ? C_BR_T : C_BR_N, 1'b0);
    exp_cnt = exp_cnt + 4'd1;
  endtask

  initial begin
    @(negedge clk);
    do_reset();

    // R-type, no stalls
    cyc(O_R, 1'b1, 1'b0, FETCH, C_F_GO, 1'b0);
    cyc(O_R, 1'b0, 1'b0, DECODE, C_DEC, 1'b0);
    cyc(O_R, 1'b0, 1'b1, EXEC_R, C_EXR, 1'b0);
    cyc(O_R, 1'b1, 1'b0, R_WB, C_RWB, 1'b0);
    exp_cnt = exp_cnt + 4'd1;

    // Load: 2 fetch stalls, 3 read stalls -> 10 cycles
    cyc(O_LD, 1'b0, 1'b0, FETCH, C_F_WAIT, 1'b0);
    cyc(O_LD, 1'b0, 1'b0, FETCH, C_F_WAIT, 1'b0);
    cyc(O_LD, 1'b1, 1'b0, FETCH, C_F_GO, 1'b0);
    cyc(O_LD, 1'b1, 1'b0, DECODE, C_DEC, 1'b0);
    cyc(O_LD, 1'b1, 1'b0, MEM_ADDR, C_MADDR, 1'b0);
    cyc(O_LD, 1'b0, 1'b0, MEM_RD, C_MRD, 1'b0);
    cyc(O_LD, 1'b0, 1'b0, MEM_RD, C_MRD, 1'b0);
    cyc(O_LD, 1'b0, 1'b0, MEM_RD, C_MRD, 1'b0);
    cyc(O_LD, 1'b1, 1'b0, MEM_RD, C_MRD, 1'b0);
    cyc(O_LD, 1'b0, 1'b0, MEM_WB, C_MWB, 1'b0);
    exp_cnt = exp_cnt + 4'd1;

    // Store, no stalls
    cyc(O_ST, 1'b1, 1'b0, FETCH, C_F_GO, 1'b0);
    cyc(O_ST, 1'b1, 1'b0, DECODE, C_DEC, 1'b0);
    cyc(O_ST, 1'b1, 1'b0, MEM_ADDR, C_MADDR, 1'b0);
    cyc(O_ST, 1'b1, 1'b0, MEM_WR, C_MWR, 1'b0);
    exp_cnt = exp_cnt + 4'd1;

    // BEQ taken, then not taken
    beq(1'b1);
    beq(1'b0);

    // Store with one write stall
    cyc(O_ST, 1'b1, 1'b0, FETCH, C_F_GO, 1'b0);
    cyc(O_ST, 1'b1, 1'b0, DECODE, C_DEC, 1'b0);
    cyc(O_ST, 1'b1, 1'b0, MEM_ADDR, C_MADDR, 1'b0);
    cyc(O_ST, 1'b0, 1'b0, MEM_WR, C_MWR, 1'b0);
    cyc(O_ST, 1'b1, 1'b0, MEM_WR, C_MWR, 1'b0);
    exp_cnt = exp_cnt + 4'd1;

    // Load aborted by reset while in MEM_RD
    cyc(O_LD, 1'b1, 1'b0, FETCH, C_F_GO, 1'b0);
    cyc(O_LD, 1'b1, 1'b0, DECODE, C_DEC, 1'b0);
    cyc(O_LD, 1'b1, 1'b0, MEM_ADDR, C_MADDR, 1'b0);
    cyc(O_LD, 1'b0, 1'b0, MEM_RD, C_MRD, 1'b0);
    do_reset();
    cyc(O_R, 1'b1, 1'b0, FETCH, C_F_GO, 1'b0);

    // Illegal opcode
    cyc(O_IL, 1'b1, 1'b0, DECODE, C_DEC, 1'b0);
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    for (int i = 0; i < 20; i++) begin
      cyc(O_IL, i[0], i[1], TRAP, C_ZERO, 1'b1);
    end
`else
    exp_cnt = exp_cnt + 4'd1;
    cyc(O_R, 1'b0, 1'b0, FETCH, C_F_WAIT, 1'b0);
`endif

    // Counter wrap: 16 retirements from zero return the count to zero
    do_reset();
    for (int i = 0; i < 16; i++) begin
      beq(i[0]);
    end
    cyc(O_R, 1'b0, 1'b0, FETCH, C_F_WAIT, 1'b0);
    checks++;
    assert (instr_retired === 4'd0) else begin
      failures++; $error("FAIL wrap obs=%0d exp=0", instr_retired);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety net so the run always ends
  initial begin
    #50000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle sequencer for the RV32I datapath subset: R-type (opcode[6:2]=01100), load (00000), store (01000), branch BEQ (11000).
- Replaces single-cycle decode with a Moore-style FSM that time-shares one ALU and one unified memory across fetch, address and data phases.
- Handshakes with memory through mem_ready and counts retired instructions.

Parameters:
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- opcode  in  5  instruction bits [6:2], taken from the IR.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory has completed the current read or write this cycle.
- ir_write  out  1  load IR from memory read data.
- pc_we  out  1  PC write enable.
- pc_src  out  1  0 = ALU result (PC+4), 1 = ALUOut register (branch target).
- i_or_d  out  1  memory address source: 0 = PC, 1 = ALUOut.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_to_reg  out  1  writeback source: 0 = ALUOut, 1 = MDR.
- reg_write  out  1  register file write enable.
- alu_src_a  out  1  0 = PC, 1 = rs1.
- alu_src_b  out  2  00 = rs2, 01 = constant 4, 10 = imm, 11 = imm<<1.
- alu_op  out  2  00 = add, 01 = sub, 10 = funct decode.
- state_o  out  4  current state encoding, for debug.
- instr_retired  out  CNT_W  retired-instruction count.

Behaviour:
- Reset (rst_n low, asynchronous): state = IDLE, instr_retired = 0. Every output is 0 in IDLE.
- IDLE -> FETCH unconditionally on the first clock edge after reset release.
- FETCH:
  - mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00.
  - Holds while mem_ready=0.
  - When mem_ready=1: ir_write=1 and pc_we=1 (pc_src=0) in that same cycle only, then -> DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (precompute branch target). Dispatch on opcode:
  - 01100 -> EXEC_R
  - 00000 or 01000 -> MEM_ADDR
  - 11000 -> BRANCH
  - other -> illegal handling (see Optional Feature).
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=10 -> R_WB.
- R_WB: reg_write=1, mem_to_reg=0 -> FETCH. Retires.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Goes to MEM_RD on load, MEM_WR on store. The opcode is re-read here; the IR is stable.
- MEM_RD: mem_read=1, i_or_d=1. Holds until mem_ready=1, then -> MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1 -> FETCH. Retires.
- MEM_WR: mem_write=1, i_or_d=1. Holds until mem_ready; in the mem_ready=1 cycle -> FETCH. Retires.
- BRANCH:
  - alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=1.
  - pc_we = zero, evaluated combinationally in this cycle.
  - -> FETCH. Retires whether or not the branch is taken.
- Any output not listed for a state is 0.
- Minimum latency with mem_ready tied high: R-type 4 cycles, load 5, store 4, BEQ 3. Each mem_ready=0 cycle in FETCH, MEM_RD or MEM_WR adds one cycle.
- instr_retired increments by 1 on the retiring edge. It wraps from 2^CNT_W-1 to 0 with no flag.
- mem_ready is ignored outside FETCH, MEM_RD and MEM_WR.
- rst_n asserted mid-instruction aborts at once: state = IDLE, counter cleared, no partial writes complete.
- Unused state encodings -> IDLE.

Optional Feature:
- Macro MC_CTRL_ILLEGAL_TRAP_EN.
- Defined: an unknown opcode in DECODE -> TRAP. TRAP is sticky until reset, drives all outputs 0 and does not retire. Adds output illegal_o (1 bit), which is 1 only in TRAP.
- Undefined: an unknown opcode is treated as a NOP. DECODE -> FETCH, the instruction retires, and the TRAP state and illegal_o port do not exist.

Decomposition:
- Package mc_ctrl_pkg holds:
  - state enum (IDLE, FETCH, DECODE, EXEC_R, R_WB, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, BRANCH, TRAP);
  - opcode constants OP_R, OP_LOAD, OP_STORE, OP_BRANCH;
  - ALU_ADD, ALU_SUB, ALU_FUNCT;
  - ALUB_RS2, ALUB_FOUR, ALUB_IMM, ALUB_IMM_SH.
- One combinational sub-module, mc_ctrl_out_dec, maps (state, mem_ready, zero) to the control outputs. The top level keeps the state register and the counter.

Test Plan:
- Reset, then opcode=01100, mem_ready=1 -> states IDLE, FETCH, DECODE, EXEC_R, R_WB. reg_write=1 only in R_WB; instr_retired=1 after 5 edges.
- Load with mem_ready low for 2 cycles in FETCH and 3 in MEM_RD -> 10 cycles total. ir_write pulses exactly once; mem_to_reg=1 and reg_write=1 in MEM_WB.
- Store (01000), mem_ready=1 -> mem_write=1 for exactly 1 cycle with i_or_d=1; reg_write is never asserted.
- BEQ with zero=1 -> pc_we=1 and pc_src=1 in BRANCH. With zero=0 -> pc_we=0. Both cases retire.
- rst_n pulsed low during MEM_RD -> outputs 0 immediately, instr_retired=0, restart through IDLE.
- Opcode 11111 -> TRAP and illegal_o=1 held for 20 cycles when MC_CTRL_ILLEGAL_TRAP_EN is defined. Otherwise back to FETCH with the count incremented. With CNT_W=4, 16 retirements wrap the count to 0.
